// File: rtl/xt_kbd_interface_if.sv
// Bundles the keyboard line pins and the port 60h/61h CPU-side signals of the XT keyboard receiver.
interface xt_kbd_interface_if;
    logic       kbd_clk_in;
    logic       kbd_data_in;
    logic       kbd_clk_oe;
    logic       kbd_data_oe;
    logic       cs_n;
    logic       rd_n;
    logic [7:0] d_out;
    logic       d_oe;
    logic       ack;
    logic       clk_en;
    logic       irq;

    // Host side: the keyboard lines, the CPU bus and the port 61h controls.
    modport master (
        output kbd_clk_in, kbd_data_in, cs_n, rd_n, ack, clk_en,
        input  kbd_clk_oe, kbd_data_oe, d_out, d_oe, irq
    );

    // Receiver side.
    modport slave (
        input  kbd_clk_in, kbd_data_in, cs_n, rd_n, ack, clk_en,
        output kbd_clk_oe, kbd_data_oe, d_out, d_oe, irq
    );
endinterface

// File: rtl/xt_kbd_interface.sv
// XT keyboard serial receiver: deserialises one start bit plus 8 data bits (LSB first),
// latches the scancode for port 60h, raises IR1 and holds the data line busy until acknowledged.
module xt_kbd_interface #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    xt_kbd_interface_if.slave bus
);
    localparam int unsigned     TW      = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FULL,
        S_CLEAR
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [2:0]             r_count;
    logic [7:0]             r_shift;
    logic [7:0]             r_code;
    logic [TW-1:0]          r_timeout;
    logic                   r_irq;
    logic                   r_data_oe;
    logic                   r_clk_oe;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;
    logic                   w_timeout;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_rd;

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s  = r_data_sync[SYNC_STAGES-1];
    assign w_fall    = r_clk_prev & ~w_clk_s;
    assign w_timeout = (r_timeout >= TO_LAST) & ~w_fall;
    assign w_rd      = ~bus.cs_n & ~bus.rd_n;

    assign bus.d_oe        = w_rd;
    assign bus.d_out       = w_rd ? r_code : '0;
    assign bus.irq         = r_irq;
    assign bus.kbd_data_oe = r_data_oe;
    assign bus.kbd_clk_oe  = r_clk_oe;

    // Bring the asynchronous keyboard lines into the clk domain and keep the previous synced clock for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_prev  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.kbd_clk_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.kbd_data_in};
            r_clk_prev  <= w_clk_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; ack outranks clk_en, and both outrank a keyboard clock fall.
    // clk_en only stops reception, so a completed frame in FULL/CLEAR keeps its irq.
    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ack) begin
                    w_next = S_CLEAR;
                end else if (bus.clk_en && w_fall && w_data_s) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.ack) begin
                    w_next = S_CLEAR;
                end else if (!bus.clk_en) begin
                    w_next = S_IDLE;
                end else if (w_fall) begin
                    w_shift = 1'b1;
                    if (r_count == 3'd7) begin
                        w_load = 1'b1;
                        w_next = S_FULL;
                    end
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_FULL: begin
                if (bus.ack) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!bus.ack) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shift register, bit count, timeout, scancode latch and the registered line/irq outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_shift   <= '0;
            r_code    <= '0;
            r_timeout <= '0;
            r_irq     <= 1'b0;
            r_data_oe <= 1'b0;
            r_clk_oe  <= 1'b1;
        end else begin
            r_clk_oe  <= ~bus.clk_en;
            r_irq     <= (w_next == S_FULL);
            r_data_oe <= (w_next == S_FULL);

            if (w_next != S_SHIFT) begin
                r_count <= '0;
            end else if (w_shift) begin
                r_count <= r_count + 3'd1;
            end

            if (r_state == S_CLEAR) begin
                r_shift <= '0;
            end else if (w_shift) begin
                r_shift <= {w_data_s, r_shift[7:1]};
            end

            if (w_load) begin
                r_code <= {w_data_s, r_shift[7:1]};
            end

            if ((r_state != S_SHIFT) || w_fall) begin
                r_timeout <= '0;
            end else if (r_timeout != '1) begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xt_kbd_interface.sv
// Self-checking bench for xt_kbd_interface: frame table with a scancode scoreboard plus hand-written corner sequences.
module tb_xt_kbd_interface;
    localparam int unsigned TO_CYC = 4096;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;
    logic [7:0] exp_q[$];

    xt_kbd_interface_if bus();

    xt_kbd_interface #(
        .TIMEOUT_CYC (TO_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        start;
        logic [7:0]  code;
        int unsigned nbits;
        int unsigned idle;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.kbd_data_in = b;
        tick(20);
        bus.kbd_clk_in = 1'b0;
        tick(20);
        bus.kbd_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic start, input logic [7:0] code, input int unsigned nbits);
        send_bit(start);
        for (int unsigned i = 0; i < nbits; i++) send_bit(code[i]);
    endtask

    task automatic read_check(input string name, input logic [7:0] exp);
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        #1;
        check({name, "_d_oe"}, {31'd0, bus.d_oe}, 32'd1);
        check({name, "_d_out"}, {24'd0, bus.d_out}, {24'd0, exp});
        @(negedge clk);
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        #1;
        check({name, "_d_out_idle"}, {24'd0, bus.d_out}, 32'd0);
    endtask

    task automatic wait_irq(input int unsigned max, output logic got);
        got = bus.irq;
        for (int unsigned i = 0; i < max && !got; i++) begin
            @(negedge clk);
            got = bus.irq;
        end
    endtask

    task automatic pop_read(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            read_check(name, e);
        end
    endtask

    task automatic ack_pulse(input string name);
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_ack_irq"}, {31'd0, bus.irq}, 32'd0);
        check({name, "_ack_busy"}, {31'd0, bus.kbd_data_oe}, 32'd0);
        @(negedge clk);
        tick(2);
        bus.ack = 1'b0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        logic [7:0] c;
        checks = 0;
        errors = 0;

        vecs[0] = '{1'b1, 8'h9C, 8, 0, 1'b1};
        vecs[1] = '{1'b1, 8'h5A, 4, TO_CYC + 5, 1'b0};
        vecs[2] = '{1'b1, 8'h2A, 8, 0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 8, 0, 1'b0};
        vecs[4] = '{1'b1, 8'h01, 8, 0, 1'b1};
        vecs[5] = '{1'b1, 8'hFF, 8, 0, 1'b1};
        vecs[6] = '{1'b1, 8'h80, 8, 0, 1'b1};

        rst = 1'b1;
        bus.kbd_clk_in = 1'b1;
        bus.kbd_data_in = 1'b1;
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.ack = 1'b0;
        bus.clk_en = 1'b1;
        tick(3);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_busy", {31'd0, bus.kbd_data_oe}, 32'd0);
        check("rst_clk_oe", {31'd0, bus.kbd_clk_oe}, 32'd1);
        check("rst_d_oe", {31'd0, bus.d_oe}, 32'd0);
        check("rst_d_out", {24'd0, bus.d_out}, 32'd0);
        rst = 1'b0;
        tick(3);
        check("clk_oe_released", {31'd0, bus.kbd_clk_oe}, 32'd0);

        // First frame 0x1C with exact irq latency around the ninth fall.
        c = 8'h1C;
        exp_q.push_back(c);
        send_bit(1'b1);
        for (int unsigned i = 0; i < 7; i++) send_bit(c[i]);
        bus.kbd_data_in = c[7];
        tick(20);
        bus.kbd_clk_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_before_fall", {31'd0, bus.irq}, 32'd0);
        @(posedge clk);
        #1;
        check("irq_after_fall", {31'd0, bus.irq}, 32'd1);
        check("busy_after_fall", {31'd0, bus.kbd_data_oe}, 32'd1);
        @(negedge clk);
        tick(17);
        bus.kbd_clk_in = 1'b1;
        tick(5);
        pop_read("frame_1c");
        check("irq_kept_after_read", {31'd0, bus.irq}, 32'd1);

        // A frame arriving while FULL must not overwrite the latched code.
        send_frame(1'b1, 8'h9C, 8);
        tick(5);
        check("full_irq_held", {31'd0, bus.irq}, 32'd1);
        read_check("full_no_overwrite", 8'h1C);
        ack_pulse("first_ack");

        // Table of frames: valid, timed-out partial, bad start bit.
        for (int unsigned v = 0; v < 7; v++) begin
            if (vecs[v].exp_irq) exp_q.push_back(vecs[v].code);
            send_frame(vecs[v].start, vecs[v].code, vecs[v].nbits);
            tick(vecs[v].idle);
            wait_irq(10, got);
            check($sformatf("vec%0d_irq", v), {31'd0, got}, {31'd0, vecs[v].exp_irq});
            if (got) begin
                check($sformatf("vec%0d_busy", v), {31'd0, bus.kbd_data_oe}, 32'd1);
                pop_read($sformatf("vec%0d_read", v));
                ack_pulse($sformatf("vec%0d", v));
            end else begin
                check($sformatf("vec%0d_busy", v), {31'd0, bus.kbd_data_oe}, 32'd0);
            end
        end

        // clk_en dropped mid-frame aborts it.
        send_frame(1'b1, 8'h05, 3);
        bus.clk_en = 1'b0;
        @(posedge clk);
        #1;
        check("clk_dis_oe", {31'd0, bus.kbd_clk_oe}, 32'd1);
        @(negedge clk);
        tick(4);
        bus.clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("clk_en_oe", {31'd0, bus.kbd_clk_oe}, 32'd0);
        @(negedge clk);
        exp_q.push_back(8'h3B);
        send_frame(1'b1, 8'h3B, 8);
        wait_irq(10, got);
        check("after_abort_irq", {31'd0, got}, 32'd1);
        pop_read("after_abort_read");
        ack_pulse("after_abort");

        // Asynchronous reset while shifting.
        send_frame(1'b1, 8'h03, 2);
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("rst_shift_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_shift_busy", {31'd0, bus.kbd_data_oe}, 32'd0);
        check("rst_shift_d_out", {24'd0, bus.d_out}, 32'd0);
        check("rst_shift_clk_oe", {31'd0, bus.kbd_clk_oe}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        tick(3);

        // Asynchronous reset while FULL.
        exp_q.push_back(8'h77);
        send_frame(1'b1, 8'h77, 8);
        wait_irq(10, got);
        check("pre_rst_full_irq", {31'd0, got}, 32'd1);
        pop_read("pre_rst_full_read");
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("rst_full_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_full_busy", {31'd0, bus.kbd_data_oe}, 32'd0);
        check("rst_full_d_out", {24'd0, bus.d_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        tick(3);

        // Latch 0x44, then ack coinciding with the final fall of 0x99 discards it.
        exp_q.push_back(8'h44);
        send_frame(1'b1, 8'h44, 8);
        wait_irq(10, got);
        check("pre_race_irq", {31'd0, got}, 32'd1);
        pop_read("pre_race_read");
        ack_pulse("pre_race");
        c = 8'h99;
        send_bit(1'b1);
        for (int unsigned i = 0; i < 7; i++) send_bit(c[i]);
        bus.kbd_data_in = c[7];
        tick(20);
        bus.kbd_clk_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        tick(3);
        check("race_irq", {31'd0, bus.irq}, 32'd0);
        check("race_busy", {31'd0, bus.kbd_data_oe}, 32'd0);
        tick(13);
        bus.kbd_clk_in = 1'b1;
        tick(5);
        check("race_irq_late", {31'd0, bus.irq}, 32'd0);
        read_check("race_code_kept", 8'h44);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xt_kbd_interface.md
Name: xt_kbd_interface

Overview:
- XT-style keyboard serial receiver that feeds IR1 of the interrupt controller.
- Deserialises one scancode frame from the keyboard clock/data lines and latches it for CPU read at port 60h.
- Raises irq1 and holds the keyboard data line low (busy) until software acknowledges via the port 61h bit-7 strobe.
- Also implements keyboard hold-in-reset via the port 61h bit-6 clock enable.

Parameters:
- TIMEOUT_CYC, 4096: system clocks with no keyboard clock falling edge before a partial frame is aborted.
- SYNC_STAGES, 2: flip-flop stages on kbd_clk_in and kbd_data_in; minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- kbd_clk_in  input  1  keyboard clock line (asynchronous).
- kbd_data_in  input  1  keyboard data line (asynchronous).
- kbd_clk_oe  output  1  1 = drive keyboard clock line low.
- kbd_data_oe  output  1  1 = drive keyboard data line low (busy).
- cs_n  input  1  port 60h select, active-low.
- rd_n  input  1  read strobe, active-low.
- d_out  output  8  read data (scancode).
- d_oe  output  1  1 = d_out is driving the bus.
- ack  input  1  port 61h bit 7 level; 1 = clear/acknowledge.
- clk_en  input  1  port 61h bit 6 level; 0 = hold keyboard clock low.
- irq  output  1  level interrupt request to IR1.

Behaviour:
- Reset (async): state IDLE, shift register 0, scancode register 0, bit count 0, timeout counter 0. Outputs: irq=0, kbd_data_oe=0, kbd_clk_oe=1 (clk_en treated as 0 until first clock after reset), d_oe=0, d_out=0x00.
- Synchronisation: kbd_clk_in and kbd_data_in each pass through SYNC_STAGES flops. fall = previous synced clk is 1 and current synced clk is 0. Data is sampled from the synced data on the fall cycle.
- kbd_clk_oe = ~clk_en, registered.
- Clock disable:
  - While clk_en=0, the receiver is forced to IDLE and the bit count is cleared.
  - A latched scancode and irq are preserved.
- Frame format: 1 start bit (must be 1), then 8 data bits LSB first. 9 falls per frame.
- States:
  - IDLE:
    - fall with data=1 -> SHIFT, count=0.
    - fall with data=0 -> stay IDLE (spurious start, ignored).
  - SHIFT:
    - Each fall shifts the data bit into bit 7 and shifts the register right; count increments.
    - On the 8th data fall -> FULL. In the same cycle the scancode register loads the completed byte (including the bit just sampled).
    - No fall for TIMEOUT_CYC consecutive clocks -> IDLE, discard the partial frame, no irq.
  - FULL:
    - irq=1 and kbd_data_oe=1 are registered, both high on the cycle after the last fall.
    - Falls are ignored; no overwrite of the scancode.
    - ack=1 -> CLEAR.
  - CLEAR:
    - irq=0, kbd_data_oe=0, shift register cleared.
    - Remains while ack=1; ack=0 -> IDLE.
    - Scancode register is retained, readable until the next frame completes.
- ack=1 while in IDLE/SHIFT: abort any partial frame, go to CLEAR.
- Read path:
  - d_oe = ~cs_n & ~rd_n, combinational.
  - d_out = scancode register when d_oe=1, else 0x00.
  - Reads have no side effect; they do not clear irq. Only ack clears irq.
- Simultaneous events:
  - ack and the final fall in the same cycle: ack wins, the frame is discarded, no irq.
  - clk_en=0 and a fall in the same cycle: clk_en wins.
- Timeout counter:
  - Saturating; cleared on every fall and whenever the state is not SHIFT.
  - Width = clog2(TIMEOUT_CYC)+1.
- rst asserted mid-frame: immediate return to reset values; the partial frame is lost.

Test Plan:
- Reset, clk_en=1, send frame start=1 + 0x1C LSB-first (falls every 40 clocks) -> irq=1 and kbd_data_oe=1 one clock after the 9th synced fall. Read with cs_n=0, rd_n=0 -> d_out=0x1C, d_oe=1; irq stays 1.
- In FULL, send a second frame 0x9C -> ignored; read still returns 0x1C. Pulse ack=1 for 3 clocks -> irq=0 and kbd_data_oe=0 the cycle after ack rises. After ack=0, a new 0x9C frame -> read returns 0x9C.
- Send start + 4 data bits, then idle TIMEOUT_CYC+5 clocks -> no irq. A full 0x2A frame afterwards -> read returns 0x2A (no bit misalignment).
- Frame with start bit 0 -> no state change. Following valid 0x01 frame -> irq=1, read returns 0x01.
- clk_en=0 mid-frame -> kbd_clk_oe=1 next clock, frame aborted. Restore clk_en=1 and send 0x3B -> read returns 0x3B.
- Assert rst while in SHIFT and again while in FULL -> irq=0, kbd_data_oe=0, d_out read=0x00 immediately (asynchronous).
- ack asserted in the same cycle as the 9th fall -> irq stays 0.
